hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/wisc_pipe_pkg.sv | 11 +
 rtl/hazard_scoreboard_sb_entry.sv | 35 +++
 rtl/hazard_scoreboard.sv | 103 ++++++++++
 tb/tb_hazard_scoreboard.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/wisc_pipe_pkg.sv
// Shared pipeline constants for the WISC hazard scoreboard and its register entries.
package wisc_pipe_pkg;

  localparam int unsigned NREGS_DEF = 16;
  localparam int unsigned DEPTH_DEF = 3;

  // Operand source encoding: RF read, or result of pipeline stage k (1 = EX).
  localparam int unsigned FWD_RF = 0;
  localparam int unsigned FWD_EX = 1;

endpackage

// File: rtl/hazard_scoreboard_sb_entry.sv
// One scoreboard slot: stages-until-writeback counter plus load flag for a single register.
module sb_entry
  import wisc_pipe_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned SW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          set,
  input  logic          set_ld,
  input  logic          flush,
  output logic [SW-1:0] cnt,
  output logic          ld
);

  localparam logic [SW-1:0] CNT_FULL = SW'(DEPTH);

  // A fresh write wins; a flush squashes only the writer sitting in EX.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      ld  <= 1'b0;
    end else if (set) begin
      cnt <= CNT_FULL;
      ld  <= set_ld;
    end else if (flush && (cnt == CNT_FULL)) begin
      cnt <= '0;
      ld  <= 1'b0;
    end else if (cnt != '0) begin
      cnt <= cnt - SW'(1);
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard: stall and forwarding-select generation for an in-order pipeline.
// Define HAZARD_SCOREBOARD_FWD_EN to enable forwarding; otherwise readers wait for RF write-through.
module hazard_scoreboard
  import wisc_pipe_pkg::*;
#(
  parameter int unsigned NREGS    = NREGS_DEF,
  parameter int unsigned DEPTH    = DEPTH_DEF,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            issue_valid,
  output logic                            issue_ready,
  input  logic [$clog2(NREGS)-1:0]        src_a,
  input  logic [$clog2(NREGS)-1:0]        src_b,
  input  logic                            src_a_used,
  input  logic                            src_b_used,
  input  logic                            wr_en,
  input  logic [$clog2(NREGS)-1:0]        wr_dst,
  input  logic                            wr_is_load,
  input  logic                            flush,
  output logic [$clog2(DEPTH+1)-1:0]      fwd_sel_a,
  output logic [$clog2(DEPTH+1)-1:0]      fwd_sel_b,
  output logic [15:0]                     stall_cnt
);

  localparam int unsigned AW = $clog2(NREGS);
  localparam int unsigned SW = $clog2(DEPTH + 1);

  logic [SW-1:0]    cnt [NREGS];
  logic [NREGS-1:0] ld;
  logic [NREGS-1:0] set;
  logic             accept;
  logic             stall;
  logic             haz_a;
  logic             haz_b;
  logic [SW-1:0]    cnt_a;
  logic [SW-1:0]    cnt_b;

  assign accept = issue_valid && issue_ready && !flush;

  for (genvar r = 0; r < NREGS; r++) begin : g_entry
    assign set[r] = accept && wr_en && (wr_dst == AW'(r)) && !(ZERO_REG && (r == 0));

    sb_entry #(
      .DEPTH (DEPTH),
      .SW    (SW)
    ) u_entry (
      .clk    (clk),
      .rst_n  (rst_n),
      .set    (set[r]),
      .set_ld (wr_is_load),
      .flush  (flush),
      .cnt    (cnt[r]),
      .ld     (ld[r])
    );
  end

  // Pre-update counters: an instruction's own write is not visible to its sources.
  assign cnt_a = cnt[src_a];
  assign cnt_b = cnt[src_b];
  assign haz_a = src_a_used && (cnt_a != '0) && !(ZERO_REG && (src_a == '0));
  assign haz_b = src_b_used && (cnt_b != '0) && !(ZERO_REG && (src_b == '0));

`ifdef HAZARD_SCOREBOARD_FWD_EN
  localparam logic [SW-1:0] CNT_FULL = SW'(DEPTH);

  logic ld_a;
  logic ld_b;

  assign ld_a = ld[src_a];
  assign ld_b = ld[src_b];

  // Only a load still in EX cannot be forwarded in time.
  assign stall = (haz_a && ld_a && (cnt_a == CNT_FULL)) ||
                 (haz_b && ld_b && (cnt_b == CNT_FULL));

  assign fwd_sel_a = haz_a ? (CNT_FULL - cnt_a + SW'(FWD_EX)) : SW'(FWD_RF);
  assign fwd_sel_b = haz_b ? (CNT_FULL - cnt_b + SW'(FWD_EX)) : SW'(FWD_RF);
`else
  logic unused_ld;

  // RF writes through in the last stage, so only cnt==1 is readable.
  assign stall = (haz_a && (cnt_a > SW'(1))) ||
                 (haz_b && (cnt_b > SW'(1)));

  assign fwd_sel_a = SW'(FWD_RF);
  assign fwd_sel_b = SW'(FWD_RF);
  assign unused_ld = ^ld;
`endif

  assign issue_ready = !(issue_valid && stall);

  // Saturating stall-cycle counter; flushed cycles are not counted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (issue_valid && !issue_ready && !flush && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard (DEPTH=3 main instance, DEPTH=7 for saturation).
module tb_hazard_scoreboard;

`ifdef HAZARD_SCOREBOARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  localparam int unsigned D0         = 3;
  localparam int unsigned D1         = 7;
  localparam int unsigned SAT_CYCLES = 76475;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        issue_valid = 1'b0;
  logic [3:0]  src_a = '0;
  logic [3:0]  src_b = '0;
  logic        src_a_used = 1'b0;
  logic        src_b_used = 1'b0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_dst = '0;
  logic        wr_is_load = 1'b0;
  logic        flush = 1'b0;

  logic        ready0;
  logic [1:0]  fwd_a0;
  logic [1:0]  fwd_b0;
  logic [15:0] stall0;
  logic        ready1;
  logic [2:0]  fwd_a1;
  logic [2:0]  fwd_b1;
  logic [15:0] stall1;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  hazard_scoreboard #(.NREGS(16), .DEPTH(D0), .ZERO_REG(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_ready(ready0),
    .src_a(src_a), .src_b(src_b), .src_a_used(src_a_used), .src_b_used(src_b_used),
    .wr_en(wr_en), .wr_dst(wr_dst), .wr_is_load(wr_is_load), .flush(flush),
    .fwd_sel_a(fwd_a0), .fwd_sel_b(fwd_b0), .stall_cnt(stall0)
  );

  hazard_scoreboard #(.NREGS(16), .DEPTH(D1), .ZERO_REG(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_ready(ready1),
    .src_a(src_a), .src_b(src_b), .src_a_used(src_a_used), .src_b_used(src_b_used),
    .wr_en(wr_en), .wr_dst(wr_dst), .wr_is_load(wr_is_load), .flush(flush),
    .fwd_sel_a(fwd_a1), .fwd_sel_b(fwd_b1), .stall_cnt(stall1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] a, input logic au,
                       input logic [3:0] b, input logic bu, input logic we,
                       input logic [3:0] wd, input logic ldi, input logic fl);
    issue_valid = v;
    src_a       = a;
    src_a_used  = au;
    src_b       = b;
    src_b_used  = bu;
    wr_en       = we;
    wr_dst      = wd;
    wr_is_load  = ldi;
    flush       = fl;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Closed-form stall count for a self-dependent instruction held valid for n cycles.
  function automatic int unsigned stalls_expected(input int unsigned n, input int unsigned d);
    int unsigned s;
    if (FWD) s = n / 2;
    else     s = (n / d) * (d - 1) + (((n % d) > 1) ? (n % d) - 1 : 0);
    return (s > 65535) ? 65535 : s;
  endfunction

  initial begin
    // Reset state.
    do_reset();
    drive(1'b1, 4'd3, 1'b1, 4'd4, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    check("rst_ready", ready0, 1);
    check("rst_fwd_a", fwd_a0, 0);
    check("rst_fwd_b", fwd_b0, 0);
    check("rst_stall_cnt", stall0, 0);

    // ALU writer R2, then back-to-back readers through EX, MEM, WB.
    do_reset();
    drive(1'b1, 4'd1, 1'b1, 4'd3, 1'b1, 1'b1, 4'd2, 1'b0, 1'b0);
    check("alu_issue_ready", ready0, 1);
    tick();
    drive(1'b1, 4'd2, 1'b1, 4'd0, 1'b0, 1'b1, 4'd9, 1'b0, 1'b0);
    check("alu_c1_ready", ready0, FWD ? 1 : 0);
    check("alu_c1_fwd_a", fwd_a0, FWD ? 1 : 0);
    tick();
    drive(1'b1, 4'd0, 1'b0, 4'd2, 1'b1, 1'b1, 4'd9, 1'b0, 1'b0);
    check("alu_c2_ready", ready0, FWD ? 1 : 0);
    check("alu_c2_fwd_b", fwd_b0, FWD ? 2 : 0);
    tick();
    check("alu_c3_ready", ready0, 1);
    check("alu_c3_fwd_b", fwd_b0, FWD ? 3 : 0);
    tick();
    check("alu_stall_cnt", stall0, FWD ? 0 : 2);

    // Load R4 then dependent reader: load-use bubble.
    do_reset();
    drive(1'b1, 4'd1, 1'b1, 4'd0, 1'b0, 1'b1, 4'd4, 1'b1, 1'b0);
    tick();
    drive(1'b1, 4'd4, 1'b1, 4'd0, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0);
    check("ld_c1_ready", ready0, 0);
    tick();
    check("ld_c2_ready", ready0, FWD ? 1 : 0);
    check("ld_c2_fwd_a", fwd_a0, FWD ? 2 : 0);
    tick();
    check("ld_c3_ready", ready0, 1);
    check("ld_c3_fwd_a", fwd_a0, FWD ? 3 : 0);
    tick();
    check("ld_stall_cnt", stall0, FWD ? 1 : 2);

    // Write to hardwired R0 creates no hazard.
    do_reset();
    drive(1'b1, 4'd1, 1'b1, 4'd0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 4'd0, 1'b1, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    check("r0_ready", ready0, 1);
    check("r0_fwd_a", fwd_a0, 0);
    check("r0_fwd_b", fwd_b0, 0);

    // Flush squashes the EX writer (R5) only; older R6 keeps draining; no issue accepted.
    do_reset();
    drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd6, 1'b0, 1'b0);
    tick();
    drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0);
    tick();
    drive(1'b1, 4'd6, 1'b1, 4'd0, 1'b0, 1'b1, 4'd7, 1'b0, 1'b1);
    check("fl_ready", ready0, FWD ? 1 : 0);
    check("fl_fwd_a", fwd_a0, FWD ? 2 : 0);
    tick();
    check("fl_stall_cnt", stall0, 0);
    drive(1'b1, 4'd5, 1'b1, 4'd6, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    check("fl_post_ready", ready0, 1);
    check("fl_r5_fwd_a", fwd_a0, 0);
    check("fl_r6_fwd_b", fwd_b0, FWD ? 3 : 0);
    tick();
    drive(1'b1, 4'd7, 1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    check("fl_r7_ready", ready0, 1);
    check("fl_r7_fwd_a", fwd_a0, 0);

    // Self-dependent load held valid: stall counter saturation, then reset mid-hazard.
    do_reset();
    drive(1'b1, 4'd2, 1'b1, 4'd0, 1'b0, 1'b1, 4'd2, 1'b1, 1'b0);
    for (int i = 0; i < SAT_CYCLES; i++) tick();
    check("sat_stall_cnt_d7", stall1, stalls_expected(SAT_CYCLES, D1));
    check("sat_stall_cnt_d3", stall0, stalls_expected(SAT_CYCLES, D0));
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    check("sat_rst_stall_cnt", stall1, 0);
    check("sat_rst_ready", ready1, 1);
    check("sat_rst_fwd_a", fwd_a1, 0);
    check("sat_rst_fwd_b", fwd_b1, 0);
    check("sat_rst_ready_d3", ready0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
